inst_fetch: RTL and testbench

//  Instruction fetch stage: owns the PC and drives a 1-cycle-latency instruction BRAM.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 48 ++++
 rtl/inst_fetch.sv | 110 +++++++++++
 tb/tb_inst_fetch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Used by the fetch stage and its skid buffer.
package cpu_pkg;

  typedef logic [31:0] inst_t;

  localparam inst_t       INST_NOP = 32'h0;
  localparam logic [31:0] PC_RESET = 32'h0;

  typedef struct packed {
    inst_t       inst;
    logic [31:0] pc;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst,pc} holding slot.
// Catches imem data that returns while the decoder stalls.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       drain_i,
  input  logic       flush_i,
  input  fetch_ent_t ent_i,
  output logic       full_o,
  output fetch_ent_t ent_o
);

  logic       full_q, full_d;
  fetch_ent_t ent_q, ent_d;

  // Next state: flush wins, then load, then drain.
  always_comb begin
    full_d = full_q;
    ent_d  = ent_q;
    if (flush_i) begin
      full_d = 1'b0;
      ent_d  = '0;
    end else if (load_i) begin
      full_d = 1'b1;
      ent_d  = ent_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      ent_q  <= '0;
    end else begin
      full_q <= full_d;
      ent_q  <= ent_d;
    end
  end

  assign full_o = full_q;
  assign ent_o  = ent_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem request, in-flight tag,
// output register and stall skid.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = PC_RESET
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid
);

  logic [31:0] pc_q, pc_d;
  logic        infl_q, infl_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  fetch_ent_t  out_q, out_d;
  logic        valid_q, valid_d;

  logic        hold;
  logic        issue;
  logic [31:0] fetch_pc;
  logic        skid_load, skid_drain;
  logic        skid_full;
  fetch_ent_t  skid_ent;
  logic        unused_bits;

  assign hold     = stall & valid_q;
  assign issue    = ~rst & (redirect | ~hold);
  assign fetch_pc = redirect ? {redirect_pc[31:2], 2'b00}
                             : pc_q;

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[ADDR_W+1:2];

  assign unused_bits = ^{redirect_pc[1:0], fetch_pc};

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (redirect),
    .ent_i   ('{inst: imem_rdata, pc: infl_pc_q}),
    .full_o  (skid_full),
    .ent_o   (skid_ent)
  );

  // Next PC, in-flight tag and output/skid steering.
  always_comb begin
    pc_d       = pc_q;
    infl_d     = issue;
    infl_pc_d  = fetch_pc;
    out_d      = out_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (issue) pc_d = fetch_pc + 32'd4;
    if (redirect) begin
      valid_d = 1'b0;
    end else if (hold) begin
      skid_load = infl_q;
    end else if (skid_full) begin
      out_d      = skid_ent;
      valid_d    = 1'b1;
      skid_drain = 1'b1;
    end else if (infl_q) begin
      out_d   = '{inst: imem_rdata, pc: infl_pc_q};
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      out_q     <= '{inst: INST_NOP, pc: 32'h0};
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
    end
  end

  // Skid data and fresh imem data can never both be pending.
  a_skid_infl: assert property (
    @(posedge clk) disable iff (rst)
    !(skid_full && infl_q)
  );

  assign inst       = out_q.inst;
  assign inst_pc    = out_q.pc;
  assign inst_valid = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch.
// Table of per-cycle vectors plus a PC-wrap sequence.
module tb_inst_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst, inst_pc;
  logic        inst_valid;

  logic        rst2, stall2, redirect2;
  logic [31:0] redirect_pc2;
  logic        imem_en2;
  logic [13:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic [31:0] inst2, inst_pc2;
  logic        inst_valid2;

  int n_chk  = 0;
  int n_fail = 0;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk         (clk),
    .rst         (rst2),
    .imem_en     (imem_en2),
    .imem_addr   (imem_addr2),
    .imem_rdata  (imem_rdata2),
    .stall       (stall2),
    .redirect    (redirect2),
    .redirect_pc (redirect_pc2),
    .inst        (inst2),
    .inst_pc     (inst_pc2),
    .inst_valid  (inst_valid2)
  );

  function automatic logic [31:0] memval(input logic [13:0] a);
    return 32'hC000_0000 | {18'b0, a};
  endfunction

  // imem models: data only valid after a request
  always @(posedge clk) begin
    imem_rdata  <= imem_en  ? memval(imem_addr)  : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_en2 ? memval(imem_addr2) : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        en;
    logic [13:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[$];

  function automatic void add(
    input logic r, s, d, input logic [31:0] rp,
    input logic e, input logic [13:0] a,
    input logic v, input logic [31:0] p);
    vec_t x;
    x.rst = r; x.stall = s; x.redir = d; x.rpc = rp;
    x.en = e; x.addr = a; x.vld = v; x.pc = p;
    tv.push_back(x);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  logic [13:0] w_addr[5];
  logic        w_vld[5];
  logic [31:0] w_pc[5];

  initial begin
    //  rst s r rpc      en addr   v pc
    add(1, 0,0, 32'h0,   0, 14'h0,  0, 32'h0);
    add(0, 0,0, 32'h0,   1, 14'h0,  0, 32'h0);
    add(0, 0,0, 32'h0,   1, 14'h1,  0, 32'h0);
    add(0, 0,0, 32'h0,   1, 14'h2,  1, 32'h0);
    add(0, 0,0, 32'h0,   1, 14'h3,  1, 32'h4);
    add(0, 1,0, 32'h0,   0, 14'h4,  1, 32'h8);
    add(0, 1,0, 32'h0,   0, 14'h4,  1, 32'h8);
    add(0, 1,0, 32'h0,   0, 14'h4,  1, 32'h8);
    add(0, 0,0, 32'h0,   1, 14'h4,  1, 32'h8);
    add(0, 0,0, 32'h0,   1, 14'h5,  1, 32'hC);
    add(0, 0,0, 32'h0,   1, 14'h6,  1, 32'h10);
    add(0, 0,0, 32'h0,   1, 14'h7,  1, 32'h14);
    add(0, 0,1, 32'h103, 1, 14'h40, 1, 32'h18);
    add(0, 0,0, 32'h0,   1, 14'h41, 0, 32'h0);
    add(0, 0,0, 32'h0,   1, 14'h42, 1, 32'h100);
    add(0, 0,0, 32'h0,   1, 14'h43, 1, 32'h104);
    add(0, 1,0, 32'h0,   0, 14'h44, 1, 32'h108);
    add(0, 1,1, 32'h200, 1, 14'h80, 1, 32'h108);
    add(0, 1,0, 32'h0,   1, 14'h81, 0, 32'h0);
    add(0, 1,0, 32'h0,   0, 14'h82, 1, 32'h200);
    add(0, 0,0, 32'h0,   1, 14'h82, 1, 32'h200);
    add(0, 0,0, 32'h0,   1, 14'h83, 1, 32'h204);
    add(0, 0,0, 32'h0,   1, 14'h84, 1, 32'h208);
    add(0, 1,0, 32'h0,   0, 14'h85, 1, 32'h20C);
    add(1, 1,0, 32'h0,   0, 14'h85, 1, 32'h20C);
    add(0, 1,0, 32'h0,   1, 14'h0,  0, 32'h0);
    add(0, 1,0, 32'h0,   1, 14'h1,  0, 32'h0);
    add(0, 1,0, 32'h0,   0, 14'h2,  1, 32'h0);
    add(0, 0,0, 32'h0,   1, 14'h2,  1, 32'h0);
    add(0, 0,0, 32'h0,   1, 14'h3,  1, 32'h4);

    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    rst2 = 1; stall2 = 0; redirect2 = 0; redirect_pc2 = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      rst         = tv[i].rst;
      stall       = tv[i].stall;
      redirect    = tv[i].redir;
      redirect_pc = tv[i].rpc;
      #1;
      chk($sformatf("v%0d.imem_en", i), 32'(imem_en), 32'(tv[i].en));
      chk($sformatf("v%0d.imem_addr", i), 32'(imem_addr), 32'(tv[i].addr));
      chk($sformatf("v%0d.inst_valid", i), 32'(inst_valid), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk($sformatf("v%0d.inst_pc", i), inst_pc, tv[i].pc);
        chk($sformatf("v%0d.inst", i), inst, memval(tv[i].pc[15:2]));
      end
      @(posedge clk);
      #1;
    end
    rst = 0; stall = 0; redirect = 0;

    // PC wrap from RESET_PC = 0xFFFF_FFF8
    w_addr = '{14'h3FFE, 14'h3FFF, 14'h0, 14'h1, 14'h2};
    w_vld  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    w_pc   = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    rst2 = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("wrap%0d.imem_en", c), 32'(imem_en2), 32'h1);
      chk($sformatf("wrap%0d.imem_addr", c), 32'(imem_addr2), 32'(w_addr[c]));
      chk($sformatf("wrap%0d.inst_valid", c), 32'(inst_valid2), 32'(w_vld[c]));
      if (w_vld[c]) begin
        chk($sformatf("wrap%0d.inst_pc", c), inst_pc2, w_pc[c]);
        chk($sformatf("wrap%0d.inst", c), inst2, memval(w_pc[c][15:2]));
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
